// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed little-endian byte image over a
// valid/ready stream, writes each assembled 32-bit word into instruction
// memory, and holds the CPU core in reset until the whole image is written.
//
// Handshake: a byte moves on a rising clk edge only when rx_valid and rx_ready
// are both high. The source holds rx_data stable while rx_valid is high.
// rx_ready depends only on the current state, never on rx_valid.
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal header word count; one bit wider than the header so that
  // a full-capacity image can be represented.
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(2**ADDR_W);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;

  logic              accept;
  logic [LEN_W-1:0]  len_next;
  logic [ADDR_W:0]   wl_inc;
  logic              last_word;

  // Byte acceptance and derived values used by the state machine.
  assign rx_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign accept    = rx_valid && rx_ready;
  assign len_next  = {rx_data, len_q[7:0]};
  assign wl_inc    = words_loaded + (ADDR_W+1)'(1);
  assign last_word = (LEN_W'(wl_inc) == len_q);

  // Loader state machine with registered memory-write and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_LEN_LO;
      len_q        <= '0;
      byte_idx     <= '0;
      asm_q        <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      boot_done    <= 1'b0;
      boot_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= rx_data;
            state      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_q[LEN_W-1:8] <= rx_data;
            if (len_next == '0) begin
              state     <= S_DONE;
              boot_done <= 1'b1;
            end else if ({1'b0, len_next} > MAX_WORDS) begin
              state    <= S_ERR;
              boot_err <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              default: begin
                // Fourth byte completes the word: write it out this edge.
                imem_we      <= 1'b1;
                imem_waddr   <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= {rx_data, asm_q};
                words_loaded <= wl_inc;
                if (last_word) begin
                  state     <= S_DONE;
                  boot_done <= 1'b1;
                end
              end
            endcase
          end
        end
        S_DONE: begin
          // Release the core one cycle after the image is complete.
          cpu_reset <= 1'b0;
        end
        S_ERR: begin
          cpu_reset <= 1'b1;
        end
        default: begin
          state <= S_LEN_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: drives byte images with random gaps and compares
// memory writes and status against a reference model built from the image.
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;
  localparam int MAX_W  = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              boot_done;
  logic              boot_err;
  logic [ADDR_W:0]   words_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected writes: {addr, data}
  logic [ADDR_W+31:0] exp_q[$];

  imem_boot_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .boot_done(boot_done),
    .boot_err(boot_err),
    .words_loaded(words_loaded)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every write pulse must match the next expected write.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        check("we_addr", 64'(imem_waddr), 64'(e[ADDR_W+31:32]));
        check("we_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  // Driver: optional idle gap, then present one byte for one edge.
  task automatic drive_byte(input logic [7:0] b, input int gap, output bit taken);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    taken    = rx_ready;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  // Reference model: image -> header count, legality, expected writes.
  task automatic model_image(input logic [7:0] img[$], output int n, output bit err);
    n   = {img[1], img[0]};
    err = (n > MAX_W);
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        logic [31:0] w;
        w = {img[2+4*k+3], img[2+4*k+2], img[2+4*k+1], img[2+4*k]};
        exp_q.push_back({ADDR_W'(k), w});
      end
    end
  endtask

  // Drive a complete image, check completion timing, then offer extra bytes.
  task automatic run_image(input string name, input logic [7:0] img[$],
                           input int gap_max, input int n_extra);
    int n;
    bit err;
    int taken_cnt;
    int extra_taken;
    bit t;
    model_image(img, n, err);
    taken_cnt = 0;
    for (int i = 0; i < img.size(); i++) begin
      if (i == img.size() - 1) check({name, "_cpu_reset_held"}, 64'(cpu_reset), 64'd1);
      drive_byte(img[i], $urandom_range(0, gap_max), t);
      taken_cnt += int'(t);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check({name, "_accepted"}, 64'(taken_cnt), 64'(img.size()));
    check({name, "_rx_ready_end"}, 64'(rx_ready), 64'd0);
    check({name, "_boot_err"}, 64'(boot_err), 64'(err));
    check({name, "_boot_done"}, 64'(boot_done), 64'(!err));
    check({name, "_cpu_reset_first"}, 64'(cpu_reset), 64'd1);
    check({name, "_last_we"}, 64'(imem_we), 64'(!err && n > 0));
    check({name, "_words"}, 64'(words_loaded), err ? 64'd0 : 64'(n));
    @(negedge clk);
    check({name, "_cpu_reset_after"}, 64'(cpu_reset), 64'(err));
    check({name, "_we_quiet"}, 64'(imem_we), 64'd0);
    extra_taken = 0;
    for (int i = 0; i < n_extra; i++) begin
      drive_byte(8'($urandom), $urandom_range(0, 2), t);
      extra_taken += int'(t);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check({name, "_extra_taken"}, 64'(extra_taken), 64'd0);
    check({name, "_words_final"}, 64'(words_loaded), err ? 64'd0 : 64'(n));
    check({name, "_exp_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic [7:0] img2[$];
  logic [7:0] img[$];

  initial begin
    bit t;
    int n;
    bit err;
    img2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Power-on reset values
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_waddr", 64'(imem_waddr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done_err", 64'({boot_done, boot_err}), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;

    // Two-word image, contiguous bytes, extra bytes after completion
    run_image("two_word", img2, 0, 3);

    // Asynchronous reset from DONE takes effect before the next edge
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_cpu_reset", 64'(cpu_reset), 64'd1);
    check("async_rx_ready", 64'(rx_ready), 64'd1);
    check("async_we", 64'(imem_we), 64'd0);
    check("async_done_err", 64'({boot_done, boot_err}), 64'd0);
    check("async_words", 64'(words_loaded), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Empty image
    img = '{8'h00, 8'h00};
    run_image("empty", img, 0, 2);
    do_reset();

    // Oversize header
    img = '{8'h01, 8'h01};
    run_image("oversize", img, 1, 3);
    do_reset();

    // Full-capacity image
    img = '{8'h00, 8'h01};
    for (int i = 0; i < 4 * MAX_W; i++) img.push_back(8'($urandom));
    run_image("full", img, 0, 1);
    do_reset();

    // Throttled source, same two-word image
    run_image("throttled", img2, 5, 4);
    do_reset();

    // Random small image with gaps
    img = '{};
    n = $urandom_range(1, 6);
    img.push_back(8'(n));
    img.push_back(8'h00);
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    run_image("random", img, 3, 2);
    do_reset();

    // Reset mid-word: header + word 0 + half of word 1
    img = '{};
    img.push_back(8'h02);
    img.push_back(8'h00);
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    model_image(img, n, err);
    void'(exp_q.pop_back());   // word 1 never completes
    for (int i = 0; i < 8; i++) drive_byte(img[i], $urandom_range(0, 2), t);
    @(negedge clk);
    rx_valid = 1'b0;
    check("midword_words", 64'(words_loaded), 64'd1);
    check("midword_cpu_reset", 64'(cpu_reset), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midword_rst_words", 64'(words_loaded), 64'd0);
    check("midword_exp_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_image("reload", img2, 2, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
